// File: rtl/grid_pkg.sv
// Shared types, constants and width helpers for the grid loader.
// Used by the loader RTL, the row banks and the bench.
package grid_pkg;

  localparam logic [7:0] GRID_ACTIVE = 8'h40;
  localparam logic [7:0] GRID_EOL    = 8'h0A;
  localparam logic [7:0] GRID_CR     = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [7:0]  bank;
    logic [15:0] row_addr;
    logic [15:0] col_addr;
    logic [63:0] data;
  } wr_packet_t;

  function automatic int col_w(input int mc);
    return $clog2(mc + 1);
  endfunction

  function automatic int row_w(input int mr);
    return $clog2(mr + 1);
  endfunction

  function automatic int bank_sel_w(input int nb);
    return (nb < 2) ? 1 : $clog2(nb);
  endfunction

  function automatic int bank_addr_w(input int mr, input int nb);
    int d;
    d = (mr + nb - 1) / nb;
    return (d < 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/grid_stream_loader_if.sv
// Bank write request bus with ack handshake.
// The loader drives the request side, the bank array acks.
interface grid_stream_loader_if #(
  parameter int BANK_SEL_W      = 2,
  parameter int BANK_ADDR_WIDTH = 6,
  parameter int COL_ADDR_WIDTH  = 8,
  parameter int TX_DATA_WIDTH   = 32
);

  logic                       wr_req_out;
  logic [BANK_SEL_W-1:0]      wr_bank_out;
  logic [BANK_ADDR_WIDTH-1:0] wr_row_addr_out;
  logic [COL_ADDR_WIDTH-1:0]  wr_col_addr_out;
  logic [TX_DATA_WIDTH-1:0]   wr_data_out;
  logic                       wr_ack_in;

  modport master (
    output wr_req_out,
    output wr_bank_out,
    output wr_row_addr_out,
    output wr_col_addr_out,
    output wr_data_out,
    input  wr_ack_in
  );

  modport slave (
    input  wr_req_out,
    input  wr_bank_out,
    input  wr_row_addr_out,
    input  wr_col_addr_out,
    input  wr_data_out,
    output wr_ack_in
  );

endinterface

// File: rtl/grid_stream_loader_row_chunker.sv
// Column counter and chunk register for the row being loaded.
// Reports when the next bit fills the chunk and when one is partial.
module row_chunker #(
  parameter int TX = 32,
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          put,
  input  logic          bit_val,
  input  logic          ack,
  input  logic          row_done,
  output logic [CW-1:0] col,
  output logic [TX-1:0] data,
  output logic          fill_last,
  output logic          partial,
  output logic [CW-1:0] base
);

  localparam int LW = $clog2(TX);

  logic [LW-1:0] idx;

  assign idx       = col[LW-1:0];
  assign fill_last = (idx == LW'(TX - 1));
  assign partial   = (idx != '0);
  assign base      = {col[CW-1:LW], {LW{1'b0}}};

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      col  <= '0;
      data <= '0;
    end else begin
      if (put) begin
        data[idx] <= bit_val;
        col       <= col + 1'b1;
      end
      if (ack) begin
        data <= '0;
      end
      if (row_done) begin
        col <= '0;
      end
    end
  end

endmodule

// File: rtl/grid_stream_loader.sv
// Parses a grid text stream into bit chunks and writes them to
// row-interleaved banks, checking row width and grid bounds.
module grid_stream_loader
  import grid_pkg::*;
#(
  parameter int          TX_DATA_WIDTH = 32,
  parameter int          MAX_COLS      = 140,
  parameter int          MAX_ROWS      = 144,
  parameter int          NUM_BANKS     = 3,
  parameter logic [7:0]  ACTIVE_CHAR   = GRID_ACTIVE,
  parameter logic [7:0]  EOL_CHAR      = GRID_EOL,
  parameter logic [7:0]  CR_CHAR       = GRID_CR,
  localparam int COL_ADDR_WIDTH  = col_w(MAX_COLS),
  localparam int ROW_W           = row_w(MAX_ROWS),
  localparam int BANK_SEL_W      = bank_sel_w(NUM_BANKS),
  localparam int BANK_ADDR_WIDTH = bank_addr_w(MAX_ROWS, NUM_BANKS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start_in,
  input  logic                      char_valid_in,
  input  logic [7:0]                char_in,
  input  logic                      eof_in,
  output logic                      char_ready_out,
  grid_stream_loader_if.master      wr,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      err_out,
  output logic [ROW_W-1:0]          rows_out,
  output logic [COL_ADDR_WIDTH-1:0] cols_out
);

  state_t state_q;
  state_t state_d;

  logic [COL_ADDR_WIDTH-1:0]  col;
  logic [COL_ADDR_WIDTH-1:0]  base;
  logic [COL_ADDR_WIDTH-1:0]  cols_q;
  logic [COL_ADDR_WIDTH-1:0]  wcol_q;
  logic [TX_DATA_WIDTH-1:0]   chunk;
  logic [ROW_W-1:0]           rows_q;
  logic [BANK_SEL_W-1:0]      bank_q;
  logic [BANK_ADDR_WIDTH-1:0] lrow_q;
  logic                       pend_row_q;
  logic                       pend_eof_q;

  logic fill_last;
  logic partial;
  logic clear;
  logic put;
  logic ack;
  logic adv_row;
  logic latch_cols;
  logic enter_wr;
  logic wr_row;
  logic wr_eof;
  logic is_eol;
  logic is_cr;
  logic is_act;
  logic first_row;
  logic full_col;
  logic full_rows;
  logic mism;

  assign is_eol    = (char_in == EOL_CHAR);
  assign is_cr     = (char_in == CR_CHAR);
  assign is_act    = (char_in == ACTIVE_CHAR);
  assign first_row = (rows_q == '0);
  assign full_col  = (col == COL_ADDR_WIDTH'(MAX_COLS));
  assign full_rows = (rows_q == ROW_W'(MAX_ROWS));
  assign mism      = !first_row && (col != cols_q);
  assign ack       = (state_q == S_WRITE) && wr.wr_ack_in;

  row_chunker #(
    .TX (TX_DATA_WIDTH),
    .CW (COL_ADDR_WIDTH)
  ) u_chunker (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .put       (put),
    .bit_val   (is_act),
    .ack       (ack),
    .row_done  (adv_row),
    .col       (col),
    .data      (chunk),
    .fill_last (fill_last),
    .partial   (partial),
    .base      (base)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clear      = 1'b0;
    put        = 1'b0;
    adv_row    = 1'b0;
    latch_cols = 1'b0;
    enter_wr   = 1'b0;
    wr_row     = 1'b0;
    wr_eof     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_in) begin
          clear   = 1'b1;
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (char_valid_in) begin
          if ((eof_in || is_eol) && col != '0) begin
            // width is checked before any flush so a bad row writes nothing more
            if (mism) begin
              state_d = S_ERR;
            end else begin
              latch_cols = first_row;
              if (partial) begin
                enter_wr = 1'b1;
                wr_row   = 1'b1;
                wr_eof   = eof_in;
                state_d  = S_WRITE;
              end else begin
                adv_row = 1'b1;
                if (eof_in) begin
                  state_d = S_DONE;
                end
              end
            end
          end else if (eof_in) begin
            state_d = S_DONE;
          end else if (is_eol || is_cr) begin
          end else if (full_col || full_rows) begin
            state_d = S_ERR;
          end else begin
            put = 1'b1;
            if (fill_last) begin
              enter_wr = 1'b1;
              state_d  = S_WRITE;
            end
          end
        end
      end
      S_WRITE: begin
        if (wr.wr_ack_in) begin
          adv_row = pend_row_q;
          state_d = pend_eof_q ? S_DONE : S_ACCEPT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rows_q     <= '0;
      cols_q     <= '0;
      bank_q     <= '0;
      lrow_q     <= '0;
      wcol_q     <= '0;
      pend_row_q <= 1'b0;
      pend_eof_q <= 1'b0;
    end else begin
      if (clear) begin
        rows_q     <= '0;
        cols_q     <= '0;
        bank_q     <= '0;
        lrow_q     <= '0;
        wcol_q     <= '0;
        pend_row_q <= 1'b0;
        pend_eof_q <= 1'b0;
      end
      if (latch_cols) begin
        cols_q <= col;
      end
      if (enter_wr) begin
        wcol_q     <= base;
        pend_row_q <= wr_row;
        pend_eof_q <= wr_eof;
      end
      // bank pointer walks row mod NUM_BANKS without a divider
      if (adv_row) begin
        rows_q <= rows_q + 1'b1;
        if (bank_q == BANK_SEL_W'(NUM_BANKS - 1)) begin
          bank_q <= '0;
          lrow_q <= lrow_q + 1'b1;
        end else begin
          bank_q <= bank_q + 1'b1;
        end
      end
    end
  end

  assign char_ready_out     = (state_q == S_ACCEPT);
  assign busy_out           = (state_q == S_ACCEPT) || (state_q == S_WRITE);
  assign done_out           = (state_q == S_DONE);
  assign err_out            = (state_q == S_ERR);
  assign rows_out           = rows_q;
  assign cols_out           = cols_q;
  assign wr.wr_req_out      = (state_q == S_WRITE);
  assign wr.wr_bank_out     = bank_q;
  assign wr.wr_row_addr_out = lrow_q;
  assign wr.wr_col_addr_out = wcol_q;
  assign wr.wr_data_out     = chunk;

endmodule

// File: tb/tb_grid_stream_loader.sv
// Randomised bench for grid_stream_loader against a line-level
// text model; writes are scoreboarded at ack time.
module tb_grid_stream_loader;
  import grid_pkg::*;

  localparam int TX = 4;
  localparam int MC = 10;
  localparam int MR = 8;
  localparam int NB = 3;
  localparam int CW = col_w(MC);
  localparam int RW = row_w(MR);
  localparam int BW = bank_sel_w(NB);
  localparam int AW = bank_addr_w(MR, NB);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start_in = 1'b0;
  logic          char_valid_in = 1'b0;
  logic [7:0]    char_in = 8'h00;
  logic          eof_in = 1'b0;
  logic          char_ready_out;
  logic          busy_out;
  logic          done_out;
  logic          err_out;
  logic [RW-1:0] rows_out;
  logic [CW-1:0] cols_out;

  grid_stream_loader_if #(
    .BANK_SEL_W      (BW),
    .BANK_ADDR_WIDTH (AW),
    .COL_ADDR_WIDTH  (CW),
    .TX_DATA_WIDTH   (TX)
  ) wr_bus ();

  grid_stream_loader #(
    .TX_DATA_WIDTH (TX),
    .MAX_COLS      (MC),
    .MAX_ROWS      (MR),
    .NUM_BANKS     (NB)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start_in       (start_in),
    .char_valid_in  (char_valid_in),
    .char_in        (char_in),
    .eof_in         (eof_in),
    .char_ready_out (char_ready_out),
    .wr             (wr_bus),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .err_out        (err_out),
    .rows_out       (rows_out),
    .cols_out       (cols_out)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  string      cur_name = "reset_state";
  int         stim[$];
  wr_packet_t exp_q[$];
  int         m_rows;
  int         m_cols;
  bit         m_done;
  bit         m_err;
  int         ack_mode = 1;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s got %0h expected %0h", cur_name, name, got, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s/%s wait bound expired", cur_name, name);
  endtask

  task automatic emit(input int base, input logic [63:0] line);
    wr_packet_t p;
    p.bank     = 8'(m_rows % NB);
    p.row_addr = 16'(m_rows / NB);
    p.col_addr = 16'(base);
    p.data     = (line >> base) & ((64'd1 << TX) - 1);
    exp_q.push_back(p);
  endtask

  task automatic finish_row(inout int col, inout logic [63:0] line);
    if (m_rows > 0 && col != m_cols) begin
      m_err = 1'b1;
    end else begin
      if (m_rows == 0) m_cols = col;
      if (col % TX != 0) emit(col - col % TX, line);
      m_rows++;
      col  = 0;
      line = '0;
    end
  endtask

  task automatic model_run();
    int          col;
    int          t;
    logic [63:0] line;
    col = 0;
    line = '0;
    m_rows = 0;
    m_cols = 0;
    m_done = 1'b0;
    m_err = 1'b0;
    exp_q.delete();
    foreach (stim[k]) begin
      if (m_done || m_err) break;
      t = stim[k];
      if (t < 0) begin
        if (col > 0) finish_row(col, line);
        if (!m_err) m_done = 1'b1;
      end else if (t == int'(GRID_CR)) begin
      end else if (t == int'(GRID_EOL)) begin
        if (col > 0) finish_row(col, line);
      end else if (col == MC || m_rows == MR) begin
        m_err = 1'b1;
      end else begin
        line[col] = (t == int'(GRID_ACTIVE));
        col++;
        if (col % TX == 0) emit(col - TX, line);
      end
    end
  endtask

  int          req_cnt = 0;
  int          cur_d = 0;
  logic [63:0] snap;

  always @(negedge clock) begin
    logic [63:0] fields;
    wr_packet_t  p;
    fields = 64'({wr_bus.wr_bank_out, wr_bus.wr_row_addr_out,
                  wr_bus.wr_col_addr_out, wr_bus.wr_data_out});
    if (wr_bus.wr_req_out === 1'b1) begin
      if (req_cnt == 0) begin
        snap  = fields;
        cur_d = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
      end else begin
        chk("wr_stable", fields, snap);
      end
      chk("ready_in_wr", 64'(char_ready_out), 64'(0));
      if (req_cnt == cur_d) begin
        wr_bus.wr_ack_in = 1'b1;
        req_cnt = 0;
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", fields, 64'(0));
        end else begin
          p = exp_q.pop_front();
          chk("wr_bank", 64'(wr_bus.wr_bank_out), 64'(p.bank));
          chk("wr_row", 64'(wr_bus.wr_row_addr_out), 64'(p.row_addr));
          chk("wr_col", 64'(wr_bus.wr_col_addr_out), 64'(p.col_addr));
          chk("wr_data", 64'(wr_bus.wr_data_out), p.data);
        end
      end else begin
        wr_bus.wr_ack_in = 1'b0;
        req_cnt++;
      end
    end else begin
      wr_bus.wr_ack_in = 1'b0;
      req_cnt = 0;
    end
  end

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) stim.push_back(int'(s[i]));
  endtask

  task automatic send(input int t, output bit stop);
    int n;
    stop = 1'b0;
    char_valid_in = 1'b1;
    eof_in = (t < 0);
    char_in = (t < 0) ? 8'h00 : 8'(t);
    n = 0;
    forever begin
      @(negedge clock);
      if (char_ready_out) break;
      if (!busy_out) begin
        stop = 1'b1;
        break;
      end
      n++;
      if (n > 100) begin
        bound_fail("ready");
        stop = 1'b1;
        break;
      end
    end
    if (!stop) @(posedge clock);
    #1;
    char_valid_in = 1'b0;
    eof_in = 1'b0;
    n = $urandom_range(0, 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic feed(input int mode, input bit do_start);
    bit stop;
    ack_mode = mode;
    if (do_start) begin
      start_in = 1'b1;
      @(posedge clock);
      #1;
      start_in = 1'b0;
    end
    foreach (stim[k]) begin
      send(stim[k], stop);
      if (stop) break;
    end
  endtask

  task automatic finish_check();
    int n;
    n = 0;
    while (!(done_out || err_out) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) bound_fail("terminal");
    @(negedge clock);
    chk("done", 64'(done_out), 64'(m_done));
    chk("err", 64'(err_out), 64'(m_err));
    chk("rows", 64'(rows_out), 64'(m_rows));
    chk("cols", 64'(cols_out), 64'(m_cols));
    chk("busy", 64'(busy_out), 64'(0));
    chk("wr_missing", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    @(posedge clock);
    #1;
  endtask

  task automatic gen_random();
    int w;
    int nr;
    int ww;
    int pick;
    stim.delete();
    w  = $urandom_range(1, MC);
    nr = $urandom_range(1, MR + 1);
    for (int r = 0; r < nr; r++) begin
      if ($urandom_range(0, 9) == 0) stim.push_back(int'(GRID_EOL));
      ww = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, MC + 1)) : w;
      for (int c = 0; c < ww; c++) begin
        pick = $urandom_range(0, 2);
        stim.push_back(pick == 0 ? int'(GRID_ACTIVE) : (pick == 1 ? 'h2E : 'h23));
        if ($urandom_range(0, 15) == 0) stim.push_back(int'(GRID_CR));
      end
      if (!(r == nr - 1 && $urandom_range(0, 1) == 1)) stim.push_back(int'(GRID_EOL));
    end
    stim.push_back(-1);
  endtask

  initial begin
    int n;
    wr_bus.wr_ack_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("ready", 64'(char_ready_out), 64'(0));
    chk("req", 64'(wr_bus.wr_req_out), 64'(0));
    chk("busy", 64'(busy_out), 64'(0));
    chk("done", 64'(done_out), 64'(0));
    chk("err", 64'(err_out), 64'(0));
    chk("rows", 64'(rows_out), 64'(0));
    chk("cols", 64'(cols_out), 64'(0));
    chk("data", 64'(wr_bus.wr_data_out), 64'(0));
    reset = 1'b0;
    @(posedge clock);
    #1;

    cur_name = "basic";
    stim.delete();
    add_str("..@@.@\n");
    stim.push_back(-1);
    model_run();
    chk("pin_n", 64'(exp_q.size()), 64'(2));
    chk("pin_d0", exp_q[0].data, 64'b1100);
    chk("pin_c1", 64'(exp_q[1].col_addr), 64'(4));
    chk("pin_d1", exp_q[1].data, 64'b0010);
    chk("pin_cols", 64'(m_cols), 64'(6));
    feed(1, 1'b1);
    finish_check();

    cur_name = "full_rows";
    stim.delete();
    repeat (4) add_str("@@@@\n");
    stim.push_back(-1);
    model_run();
    chk("pin_n", 64'(exp_q.size()), 64'(4));
    chk("pin_b1", 64'(exp_q[1].bank), 64'(1));
    chk("pin_b3", 64'(exp_q[3].bank), 64'(0));
    chk("pin_r3", 64'(exp_q[3].row_addr), 64'(1));
    chk("pin_d3", exp_q[3].data, 64'hF);
    feed(1, 1'b1);
    finish_check();

    cur_name = "stall";
    stim.delete();
    add_str("@.@@.@@.\n@@@@@@@@\n");
    stim.push_back(-1);
    model_run();
    feed(5, 1'b1);
    finish_check();

    cur_name = "cr_no_nl";
    stim.delete();
    add_str("@.");
    stim.push_back(int'(GRID_CR));
    add_str("\n.@");
    stim.push_back(-1);
    model_run();
    chk("pin_n", 64'(exp_q.size()), 64'(2));
    chk("pin_d0", exp_q[0].data, 64'b0001);
    chk("pin_d1", exp_q[1].data, 64'b0010);
    chk("pin_b1", 64'(exp_q[1].bank), 64'(1));
    chk("pin_rows", 64'(m_rows), 64'(2));
    feed(1, 1'b1);
    finish_check();

    cur_name = "width_err";
    stim.delete();
    add_str("@@@\n@@\n");
    stim.push_back(-1);
    model_run();
    chk("pin_err", 64'(m_err), 64'(1));
    chk("pin_n", 64'(exp_q.size()), 64'(1));
    feed(1, 1'b1);
    finish_check();

    cur_name = "col_overflow";
    stim.delete();
    add_str("@@@@@@@@@@@\n");
    stim.push_back(-1);
    model_run();
    chk("pin_err", 64'(m_err), 64'(1));
    chk("pin_n", 64'(exp_q.size()), 64'(2));
    feed(0, 1'b1);
    finish_check();

    cur_name = "row_overflow";
    stim.delete();
    repeat (MR + 1) add_str("@\n");
    stim.push_back(-1);
    model_run();
    chk("pin_rows", 64'(m_rows), 64'(MR));
    chk("pin_err", 64'(m_err), 64'(1));
    feed(0, 1'b1);
    finish_check();

    cur_name = "reset_mid";
    stim.delete();
    add_str("@@@@\n");
    model_run();
    feed(1, 1'b1);
    chk("rows_pre", 64'(rows_out), 64'(1));
    chk("wr_missing", 64'(exp_q.size()), 64'(0));
    stim.delete();
    add_str("@@@@");
    feed(50, 1'b0);
    n = 0;
    while (wr_bus.wr_req_out !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) bound_fail("req");
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("req", 64'(wr_bus.wr_req_out), 64'(0));
    chk("busy", 64'(busy_out), 64'(0));
    chk("rows", 64'(rows_out), 64'(0));
    chk("cols", 64'(cols_out), 64'(0));
    chk("data", 64'(wr_bus.wr_data_out), 64'(0));
    reset = 1'b0;
    @(posedge clock);
    #1;

    cur_name = "reload";
    stim.delete();
    add_str("@.@\n.@.\n@@@\n");
    stim.push_back(-1);
    model_run();
    feed(1, 1'b1);
    finish_check();

    for (int s = 0; s < 25; s++) begin
      cur_name = $sformatf("rand%0d", s);
      gen_random();
      model_run();
      feed(-1, 1'b1);
      finish_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/grid_stream_loader.md
Name: grid_stream_loader

Overview:
- Hardware replacement for the bench-side input parser that stages the grid into the row banks.
- Accepts a byte stream of grid text. Maps ACTIVE_CHAR to 1 and any other printable character to 0, and assembles TX_DATA_WIDTH-bit chunks per row.
- Issues bank write requests over an ack handshake.
- Generalised in chunk width, grid size and bank count. Adds features the staging path never had: row-width checking, overflow errors, CR stripping and missing-final-newline handling.

Parameters:
- TX_DATA_WIDTH, 32, bits per write chunk (power of two).
- MAX_COLS, 140, maximum grid columns.
- MAX_ROWS, 144, maximum grid rows.
- NUM_BANKS, 3, rows are interleaved row mod NUM_BANKS.
- ACTIVE_CHAR, 8'h40, character mapped to 1 ('@').
- EOL_CHAR, 8'h0A, row terminator.
- CR_CHAR, 8'h0D, silently discarded.

Derived values:
- COL_ADDR_WIDTH = $clog2(MAX_COLS+1)
- ROW_W = $clog2(MAX_ROWS+1)
- BANK_SEL_W = max(1, $clog2(NUM_BANKS))
- BANK_ADDR_WIDTH = $clog2(ceil(MAX_ROWS/NUM_BANKS))

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start_in  in  1  begin a new load; honoured only in IDLE, DONE or ERR
- char_valid_in  in  1  char_in is valid
- char_in  in  8  input character
- eof_in  in  1  end of stream; consumed with the same valid/ready rule as a character
- char_ready_out  out  1  block can accept a character or eof this cycle
- wr_req_out  out  1  write request
- wr_bank_out  out  BANK_SEL_W  target bank
- wr_row_addr_out  out  BANK_ADDR_WIDTH  bank-local row
- wr_col_addr_out  out  COL_ADDR_WIDTH  chunk base column (multiple of TX_DATA_WIDTH)
- wr_data_out  out  TX_DATA_WIDTH  chunk data; bit i = column base+i
- wr_ack_in  in  1  memory accepted the request
- busy_out  out  1  state is not IDLE, DONE or ERR
- done_out  out  1  load complete; held until start_in or reset
- err_out  out  1  load aborted; held until start_in or reset
- rows_out  out  ROW_W  rows loaded
- cols_out  out  COL_ADDR_WIDTH  width latched from the first row

Behaviour:
- Reset: all outputs 0, state IDLE, partial chunk, counters and bank pointer cleared. Applies mid-operation; any outstanding request is dropped without waiting for ack.
- States:
  - IDLE: start_in moves to ACCEPT and clears the counters.
  - ACCEPT: char_ready_out=1.
  - WRITE: wr_req_out=1, char_ready_out=0.
  - DONE and ERR: terminal until start_in or reset.
- A character or eof is consumed on any cycle with valid & ready. eof takes priority over a character in the same cycle.
- Non-EOL character, col < MAX_COLS:
  - data[col % TX] is set to (char == ACTIVE_CHAR); col increments.
  - If col % TX becomes TX-1 at consumption, go to WRITE. wr_req_out rises on the next cycle.
- Non-EOL character, col == MAX_COLS, or row == MAX_ROWS: go to ERR.
- CR_CHAR: consumed with no effect.
- EOL with col == 0: blank line, ignored.
- EOL with col > 0:
  - If a partial chunk is pending (col % TX != 0), go to WRITE with the upper bits zero.
  - If this is the first row, latch cols_out = col. Otherwise, if col != cols_out, go to ERR (no write is issued).
  - After any write completes: row++, col=0. The bank pointer wraps 0..NUM_BANKS-1; on wrap the local row increments. No divider is used.
- eof: if col > 0, behave as EOL (flush and count the row), then go to DONE. Otherwise go to DONE directly.
- WRITE: all wr_* fields stay stable while wr_req_out=1. If wr_ack_in=1 in a cycle with req high, the transfer completes and req is 0 on the next cycle. Zero-wait ack is legal, giving one request cycle. The chunk register clears on ack.
- Throughput: at most one character per cycle outside WRITE.
- start_in while busy is ignored.

Decomposition:
- Shared package grid_pkg holds:
  - wr_packet_t {bank, row_addr, col_addr, data}
  - width-derivation functions
  - EOL/CR/ACTIVE constants, reused by the banks and the bench.
- One natural sub-module, row_chunker: bit insertion, the col counter, chunk-full and partial-pending flags.
- The FSM, row/bank counters and handshake stay in grid_stream_loader.

Test Plan (TX_DATA_WIDTH=4, MAX_COLS=10, MAX_ROWS=8, NUM_BANKS=3, ack after 1 cycle unless stated):
- "..@@.@\n" then eof -> writes (b0,r0,c0,4'b1100) and (b0,r0,c4,4'b0010); rows_out=1, cols_out=6, done_out=1.
- Four lines "@@@@\n" -> one write per row, data 4'hF, (bank,row) = (0,0),(1,0),(2,0),(0,1); no extra flush write at EOL.
- Ack held low 5 cycles on the first write -> wr_req and fields stable for 5 cycles, char_ready_out=0, no character lost.
- "@.\r\n.@" then eof (no final newline) -> writes 4'b0001 (b0,r0) and 4'b0010 (b1,r0); rows_out=2, done_out=1.
- "@@@\n@@\n" -> err_out=1 at the second EOL, only one write issued, done_out=0. Eleven-character line -> err_out=1.
- Reset asserted while WRITE is waiting for ack -> next cycle wr_req_out=0, busy_out=0, rows_out=0. start_in then reloads correctly.
